// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bus: Start/Ack program handshake, decoder flags and fetch-side outputs.
// The master drives requests and decoder flags; the slave (sequencer) drives PC and status.
interface fetch_sequencer_if #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             halt;
    logic             branch_en;
    logic [PC_W-1:0]  branch_target;
    logic [PC_W-1:0]  prog_ctr;
    logic             running;
    logic             ack;
    logic             timeout;
    logic [1:0]       prog_idx;
    logic [CNT_W-1:0] cycle_ct;

    modport master (
        output start, halt, branch_en, branch_target,
        input  prog_ctr, running, ack, timeout, prog_idx, cycle_ct
    );

    modport slave (
        input  start, halt, branch_en, branch_target,
        output prog_ctr, running, ack, timeout, prog_idx, cycle_ct
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, sequences programs back-to-back via Start/Ack,
// applies LUT branch redirects and force-completes programs that exceed the cycle limit.
module fetch_sequencer #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned NUM_PROG   = 3,
    parameter int unsigned PROG0_BASE = 0,
    parameter int unsigned PROG1_BASE = 256,
    parameter int unsigned PROG2_BASE = 512,
    parameter int unsigned MAX_CYCLES = 65000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fetch_sequencer_if.slave fs_io
);

    typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_CYCLES - 1);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, base_pc;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       idx_q, idx_d, idx_inc;
    logic             tmo_q, tmo_d;
    logic             run_q, ack_q;

    always_comb begin
        case (idx_q)
            2'd1:    base_pc = PC_W'(PROG1_BASE);
            2'd2:    base_pc = PC_W'(PROG2_BASE);
            default: base_pc = PC_W'(PROG0_BASE);
        endcase
    end

    assign idx_inc = (32'(idx_q) + 32'd1 >= NUM_PROG) ? 2'd0 : idx_q + 2'd1;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (fs_io.start) begin
                    state_d = StArmed;
                    pc_d    = base_pc;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                end
            end
            StArmed: begin
                if (!fs_io.start) state_d = StRun;
            end
            StRun: begin
                if (fs_io.start) begin
                    // Abort restarts the same program from its entry point.
                    state_d = StArmed;
                    pc_d    = base_pc;
                    cnt_d   = '0;
                end else if (fs_io.halt) begin
                    state_d = StDone;
                    cnt_d   = cnt_inc;
                    idx_d   = idx_inc;
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                    cnt_d   = cnt_inc;
                    idx_d   = idx_inc;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    pc_d  = fs_io.branch_en ? fs_io.branch_target : pc_q + PC_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= 1'b0;
            run_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            run_q   <= (state_d == StRun);
            ack_q   <= (state_d == StDone);
        end
    end

    assign fs_io.prog_ctr = pc_q;
    assign fs_io.running  = run_q;
    assign fs_io.ack      = ack_q;
    assign fs_io.timeout  = tmo_q;
    assign fs_io.prog_idx = idx_q;
    assign fs_io.cycle_ct = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner sequences and a
// randomized run compared against a cycle-level behavioural model.
module tb_fetch_sequencer;

    localparam int PcW    = 10;
    localparam int CntW   = 16;
    localparam int MaxCyc = 20;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fetch_sequencer_if #(.PC_W(PcW), .CNT_W(CntW)) bus ();

    fetch_sequencer #(
        .PC_W      (PcW),
        .CNT_W     (CntW),
        .MAX_CYCLES(MaxCyc)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .fs_io(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s, h, b, t;
        int pc, run, ack, tmo, idx, cnt;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference: phase 0 idle, 1 armed, 2 run, 3 done.
    int bases[3] = '{0, 256, 512};
    int m_phase, m_pc, m_cnt, m_idx, m_tmo;

    task automatic add(input int s, h, b, t, pc, run, ack, tmo, idx, cnt);
        vec_t v;
        v = '{s, h, b, t, pc, run, ack, tmo, idx, cnt};
        vecs.push_back(v);
    endtask

    task automatic check(input string tag, input string fld, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", tag, fld, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int pc, run, ack, tmo, idx, cnt);
        check(tag, "pc",  int'(bus.prog_ctr), pc);
        check(tag, "run", int'(bus.running),  run);
        check(tag, "ack", int'(bus.ack),      ack);
        check(tag, "tmo", int'(bus.timeout),  tmo);
        check(tag, "idx", int'(bus.prog_idx), idx);
        check(tag, "cnt", int'(bus.cycle_ct), cnt);
    endtask

    task automatic drive(input int s, h, b, t);
        bus.start         = s[0];
        bus.halt          = h[0];
        bus.branch_en     = b[0];
        bus.branch_target = t[PcW-1:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_phase = 0; m_pc = 0; m_cnt = 0; m_idx = 0; m_tmo = 0;
    endtask

    task automatic model_step(input int s, h, b, t);
        int nxt_cnt;
        nxt_cnt = (m_cnt == (1 << CntW) - 1) ? m_cnt : m_cnt + 1;
        if (m_phase == 0 || m_phase == 3) begin
            if (s != 0) begin
                m_phase = 1; m_pc = bases[m_idx]; m_cnt = 0; m_tmo = 0;
            end
        end else if (m_phase == 1) begin
            if (s == 0) m_phase = 2;
        end else begin
            if (s != 0) begin
                m_phase = 1; m_pc = bases[m_idx]; m_cnt = 0;
            end else if (h != 0 || m_cnt == MaxCyc - 1) begin
                if (h == 0) m_tmo = 1;
                m_phase = 3; m_cnt = nxt_cnt; m_idx = (m_idx + 1) % 3;
            end else begin
                m_cnt = nxt_cnt;
                m_pc  = (b != 0) ? t : (m_pc + 1) % (1 << PcW);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive(0, 0, 0, 0);
        #12;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // s h b t | pc run ack tmo idx cnt
        add(0, 1, 1, 5,    0,   0, 0, 0, 0, 0);
        add(1, 0, 0, 0,    0,   0, 0, 0, 0, 0);
        add(1, 1, 1, 99,   0,   0, 0, 0, 0, 0);
        add(1, 0, 0, 0,    0,   0, 0, 0, 0, 0);
        add(0, 0, 0, 0,    0,   1, 0, 0, 0, 0);
        add(0, 0, 0, 0,    1,   1, 0, 0, 0, 1);
        add(0, 0, 0, 0,    2,   1, 0, 0, 0, 2);
        add(0, 0, 0, 0,    3,   1, 0, 0, 0, 3);
        add(0, 0, 0, 0,    4,   1, 0, 0, 0, 4);
        add(0, 0, 0, 0,    5,   1, 0, 0, 0, 5);
        add(0, 1, 0, 0,    5,   0, 1, 0, 1, 6);
        add(0, 0, 1, 7,    5,   0, 1, 0, 1, 6);
        add(1, 0, 0, 0,    256, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0,    256, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0,    257, 1, 0, 0, 1, 1);
        add(0, 0, 1, 300,  300, 1, 0, 0, 1, 2);
        add(0, 0, 0, 0,    301, 1, 0, 0, 1, 3);
        add(0, 1, 1, 100,  301, 0, 1, 0, 2, 4);
        add(1, 1, 0, 0,    512, 0, 0, 0, 2, 0);
        add(0, 0, 0, 0,    512, 1, 0, 0, 2, 0);
        add(0, 1, 0, 0,    512, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0,    0,   0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].h, vecs[i].b, vecs[i].t);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].run, vecs[i].ack,
                      vecs[i].tmo, vecs[i].idx, vecs[i].cnt);
        end

        // Timeout: program 0 runs MaxCyc cycles without Halt.
        drive(0, 0, 0, 0);
        tick();
        check_all("tmo_first", 0, 1, 0, 0, 0, 0);
        repeat (MaxCyc - 1) tick();
        check_all("tmo_last", MaxCyc - 1, 1, 0, 0, 0, MaxCyc - 1);
        tick();
        check_all("tmo_done", MaxCyc - 1, 0, 1, 1, 1, MaxCyc);
        drive(1, 0, 0, 0);
        tick();
        check_all("tmo_clear", 256, 0, 0, 0, 1, 0);

        // Abort mid-run at PC 260, then asynchronous reset between edges.
        drive(0, 0, 0, 0);
        tick();
        repeat (4) tick();
        check_all("abort_pre", 260, 1, 0, 0, 1, 4);
        drive(1, 0, 0, 0);
        tick();
        check_all("abort", 256, 0, 0, 0, 1, 0);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        tick();
        check_all("post_rst", 0, 0, 0, 0, 0, 0);

        // PC wrap after a branch to the top address.
        drive(0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 1023);
        tick();
        check_all("br_top", 1023, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0);
        tick();
        check_all("pc_wrap", 0, 1, 0, 0, 0, 2);

        // Randomized run against the behavioural model.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            int s, h, b, t;
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_all("rnd_rst", m_pc, 0, 0, 0, 0, 0);
                rst = 1'b0;
            end
            s = ($urandom_range(0, 7) == 0) ? 1 : 0;
            h = ($urandom_range(0, 15) == 0) ? 1 : 0;
            b = ($urandom_range(0, 3) == 0) ? 1 : 0;
            t = int'($urandom_range(0, 1023));
            drive(s, h, b, t);
            tick();
            model_step(s, h, b, t);
            check_all($sformatf("rnd%0d", i), m_pc, (m_phase == 2) ? 1 : 0,
                      (m_phase == 3) ? 1 : 0, m_tmo, m_idx, m_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
